// File: rtl/uart_rx_frame_chk_pkg.sv
// Shared definitions for the UART receive frame checker: FSM states, parity
// sense constants and the bit-counter width helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Wide enough to count 0..data_width inclusive.
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_chk_if.sv
// Bundle of sampler-side inputs, configuration and frame/statistics outputs
// for the UART receive frame checker.
interface uart_rx_frame_chk_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);

  logic                  frame_start;
  logic                  sample_valid;
  logic                  sample_data;
  logic                  par_en;
  logic                  par_typ;
  logic                  stop2;
  logic                  cnt_clr;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  frame_done;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  glitch_cnt;
  logic [CNT_WIDTH-1:0]  par_err_cnt;
  logic [CNT_WIDTH-1:0]  stp_err_cnt;

  modport master (
    output frame_start, sample_valid, sample_data, par_en, par_typ, stop2, cnt_clr,
    input  p_data, data_valid, frame_done, strt_glitch, par_err, stp_err, busy,
    input  glitch_cnt, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  frame_start, sample_valid, sample_data, par_en, par_typ, stop2, cnt_clr,
    output p_data, data_valid, frame_done, strt_glitch, par_err, stp_err, busy,
    output glitch_cnt, par_err_cnt, stp_err_cnt
  );

endinterface

// File: rtl/uart_rx_frame_chk_err_sat_cnt.sv
// Saturating event counter: clear beats increment, holds at all-ones.
module err_sat_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: validates start/parity/stop bits, deserialises
// data LSB-first and keeps saturating error statistics.
module uart_rx_frame_chk
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                CLK,
  input  logic                RST,
  uart_rx_frame_chk_if.slave  bus
);

  localparam int BCW = bit_cnt_width(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;
  logic                  cfg_par_en_q, cfg_par_en_d;
  logic                  cfg_par_typ_q, cfg_par_typ_d;
  logic                  cfg_stop2_q, cfg_stop2_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  stp_now;
  logic                  finish;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    par_acc_d     = par_acc_q;
    par_flag_d    = par_flag_q;
    stp_flag_d    = stp_flag_q;
    cfg_par_en_d  = cfg_par_en_q;
    cfg_par_typ_d = cfg_par_typ_q;
    cfg_stop2_d   = cfg_stop2_q;
    p_data_d      = p_data_q;
    data_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    strt_glitch_d = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    finish        = 1'b0;
    // Stop flag including the stop bit currently on the line.
    stp_now       = stp_flag_q | ~bus.sample_data;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          cfg_par_en_d  = bus.par_en;
          cfg_par_typ_d = bus.par_typ;
          cfg_stop2_d   = bus.stop2;
          par_flag_d    = 1'b0;
          stp_flag_d    = 1'b0;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        if (bus.sample_valid) begin
          if (bus.sample_data) begin
            strt_glitch_d = 1'b1;
            frame_done_d  = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            bit_cnt_d = '0;
            par_acc_d = 1'b0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bus.sample_valid) begin
          shift_d   = {bus.sample_data, shift_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ bus.sample_data;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            state_d = cfg_par_en_q ? ST_PARITY : ST_STOP1;
          end
        end
      end
      ST_PARITY: begin
        if (bus.sample_valid) begin
          par_flag_d = par_acc_q ^ bus.sample_data ^ (cfg_par_typ_q == PAR_ODD);
          state_d    = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (bus.sample_valid) begin
          if (cfg_stop2_q) begin
            stp_flag_d = stp_now;
            state_d    = ST_STOP2;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (bus.sample_valid) begin
          finish = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // All end-of-frame outputs are produced together from the final stop sample.
    if (finish) begin
      frame_done_d = 1'b1;
      par_err_d    = par_flag_q;
      stp_err_d    = stp_now;
      if (!(par_flag_q | stp_now)) begin
        data_valid_d = 1'b1;
        p_data_d     = shift_q;
      end
      par_flag_d = 1'b0;
      stp_flag_d = 1'b0;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      par_acc_q     <= 1'b0;
      par_flag_q    <= 1'b0;
      stp_flag_q    <= 1'b0;
      cfg_par_en_q  <= 1'b0;
      cfg_par_typ_q <= 1'b0;
      cfg_stop2_q   <= 1'b0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      par_acc_q     <= par_acc_d;
      par_flag_q    <= par_flag_d;
      stp_flag_q    <= stp_flag_d;
      cfg_par_en_q  <= cfg_par_en_d;
      cfg_par_typ_q <= cfg_par_typ_d;
      cfg_stop2_q   <= cfg_stop2_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      frame_done_q  <= frame_done_d;
      strt_glitch_q <= strt_glitch_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
    end
  end

  // Counters step on the same edge that raises their pulse, so count and pulse appear together.
  logic [2:0]           err_inc;
  logic [CNT_WIDTH-1:0] err_cnt [3];

  assign err_inc = {stp_err_d, par_err_d, strt_glitch_d};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      err_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (bus.cnt_clr),
        .inc (err_inc[gi]),
        .cnt (err_cnt[gi])
      );
    end
  endgenerate

  assign bus.p_data      = p_data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.strt_glitch = strt_glitch_q;
  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.glitch_cnt  = err_cnt[0];
  assign bus.par_err_cnt = err_cnt[1];
  assign bus.stp_err_cnt = err_cnt[2];

endmodule

// File: doc/uart_rx_frame_chk.md
Name: uart_rx_frame_chk

Overview:
Parametrised UART receive frame checker and deserialiser, successor to the single start-bit glitch flop. It sits between the oversampling bit sampler and the RX output register. It validates start, parity and stop bits, deserialises data LSB-first, and keeps saturating per-error statistics. It consumes one sampled bit per sample_valid pulse; sampling itself is upstream.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 legal)
CNT_WIDTH, 8, width of each saturating error counter

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-low
frame_start  input  1  one-cycle pulse from the falling-edge detector; opens a frame when idle
sample_valid  input  1  one-cycle pulse: sample_data holds a settled bit
sample_data  input  1  sampled line value
par_en  input  1  parity bit present
par_typ  input  1  0 = even, 1 = odd
stop2  input  1  two stop bits expected
cnt_clr  input  1  synchronous clear of all counters
p_data  output  DATA_WIDTH  received word, held until the next good frame
data_valid  output  1  one-cycle pulse: good frame, p_data updated
frame_done  output  1  one-cycle pulse at the end of every frame, including aborted ones
strt_glitch  output  1  one-cycle pulse: start bit sampled high
par_err  output  1  one-cycle pulse with frame_done: parity mismatch
stp_err  output  1  one-cycle pulse with frame_done: any stop bit sampled low
busy  output  1  high in any state other than IDLE
glitch_cnt  output  CNT_WIDTH  start-glitch count
par_err_cnt  output  CNT_WIDTH  parity-error count
stp_err_cnt  output  CNT_WIDTH  stop-error count

Behaviour:
- Reset: FSM returns to IDLE; all outputs and counters go to 0; internal shift register, bit counter and flags are cleared. Reset in mid-frame aborts the frame with no pulses.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. Only sample_valid advances states after START.
- IDLE: on frame_start, latch par_en, par_typ and stop2, then go to START. Configuration changes mid-frame have no effect. frame_start outside IDLE is ignored.
- START, on sample_valid:
  - bit = 1: strt_glitch = 1 and frame_done = 1 for the next cycle; glitch_cnt += 1; return to IDLE.
  - bit = 0: go to DATA with bit counter = 0.
- DATA, on each sample_valid: shift the bit in at the MSB and shift right, so p_data ends LSB-first. XOR the bit into the parity accumulator. After DATA_WIDTH bits, go to PARITY if latched par_en is set, else STOP1.
- PARITY: the mismatch flag is set when (accumulator XOR sample_data XOR par_typ) = 1. Then go to STOP1.
- STOP1: sample_data = 0 sets the stop flag. Go to STOP2 if latched stop2 is set, else finish.
- STOP2: same check as STOP1, OR-ed into the stop flag, then finish.
- Finish (the cycle after the final stop sample_valid), all outputs valid together:
  - frame_done = 1; par_err and stp_err reflect the flags.
  - If no flag is set: data_valid = 1 and p_data is loaded.
  - If any flag is set: p_data keeps its old value.
  - Flags clear; FSM returns to IDLE. frame_start on the finish cycle itself is accepted.
- Latency: exactly one CLK from the qualifying sample_valid to its pulses.
- Counters:
  - Each increments by 1 on its error pulse and saturates at all-ones (no wrap).
  - cnt_clr has priority over a simultaneous increment; the result is 0.
  - par_err and stp_err in the same frame increment both counters.
- sample_valid in IDLE is ignored. Two sample_valid pulses on consecutive cycles are both accepted.

Decomposition:
- Shared package uart_rx_pkg holds the FSM state enum, the PAR_EVEN/PAR_ODD constants, and bit-count width = $clog2(DATA_WIDTH+1).
- One natural sub-module: err_sat_cnt (parameter CNT_WIDTH; inputs inc and clr; clr wins; saturating), instantiated three times.

Test Plan:
- DATA_WIDTH=8, no parity, 1 stop, frame 0,0x55 LSB-first,1 -> data_valid pulse, p_data=0x55, no error pulses, busy low after finish.
- Start sampled 1 -> strt_glitch and frame_done pulse one cycle later; glitch_cnt=1; no data_valid; back to IDLE.
- par_en=1, par_typ=0, data 0x07, parity bit 0 -> par_err=1, par_err_cnt=1, p_data unchanged; repeat with parity 1 -> data_valid, p_data=0x07.
- stop2=1, second stop sampled 0 -> stp_err=1 at finish, stp_err_cnt=1; par_typ toggled mid-frame has no effect.
- CNT_WIDTH=2, five start glitches -> glitch_cnt = 1,2,3,3,3; cnt_clr on the same cycle as a sixth glitch -> glitch_cnt=0.
- RST low mid-DATA -> busy=0, no pulses, counters 0; next clean frame of 0xA3 -> p_data=0xA3.
